if_id_redirect: RTL
===================

# if_id_redirect

Fetch-stage PC register plus IF/ID pipeline register, acting as the consumer of the hazard unit's IF/ID flush and of the jump/branch redirect requests. Each cycle it selects the next PC (sequential, jump target from ID, branch target from EX), latches the fetched instruction into IF/ID, and honours stall and flush. It also counts flushes and flags inconsistent flush/redirect combinations for debug. It sits between instruction memory and the ID stage of the pipeline processor.

## Interface
- PC_WIDTH, 32, PC and target width
- INST_WIDTH, 32, instruction width
- RESET_PC, 32'h0040_0000, PC value after reset
- CNT_WIDTH, 16, flush counter width
- i_clk  input  1  rising-edge clock
- i_rst_n  input  1  reset; asynchronous, active-low
- i_stall  input  1  load-use stall: hold PC and IF/ID
- i_IF_ID_Flush  input  1  flush IF/ID (from hazard unit)
- i_jump  input  1  jump decoded in ID
- i_jump_target  input  PC_WIDTH  jump destination
- i_branch_taken  input  1  branch resolved taken in EX
- i_branch_target  input  PC_WIDTH  branch destination
- i_inst  input  INST_WIDTH  instruction memory data at o_pc (combinational)
- o_pc  output  PC_WIDTH  current fetch PC
- o_IF_ID_inst  output  INST_WIDTH  registered instruction
- o_IF_ID_pc_plus4  output  PC_WIDTH  registered PC+4 of that instruction
- o_IF_ID_valid  output  1  IF/ID holds a real instruction
- o_flush_count  output  CNT_WIDTH  saturating count of flush cycles
- o_protocol_err  output  1  sticky inconsistency flag

## Operation
- Next-PC priority: branch_taken > jump > stall > sequential.
  - branch_taken: pc <= {i_branch_target[PC_WIDTH-1:2],2'b00}
  - else jump: pc <= {i_jump_target[PC_WIDTH-1:2],2'b00}
  - else stall: pc holds
  - else pc <= pc + 4, modulo 2^PC_WIDTH (wraps to 0)
- Redirect overrides stall: the stalled instruction is discarded anyway by the flush.
- IF/ID priority: flush > stall > load.
  - flush: inst <= NOP (all zeros), pc_plus4 <= 0, valid <= 0
  - stall: all IF/ID fields hold
  - load: inst <= i_inst, pc_plus4 <= o_pc + 4, valid <= 1
- Flush counter: increments by 1 on each cycle with i_IF_ID_Flush = 1; saturates at all-ones (no wrap).
- o_protocol_err: set when i_IF_ID_Flush != (i_jump | i_branch_taken) in any cycle; sticky until reset.
- Both jump and branch_taken high: branch wins (older instruction); no error.

## Timing
- Reset (i_rst_n low, asynchronous): o_pc = RESET_PC, o_IF_ID_inst = 0, o_IF_ID_pc_plus4 = 0, o_IF_ID_valid = 0, o_flush_count = 0, o_protocol_err = 0. Outputs change immediately on assertion, without waiting for a clock edge.
- Reset release: first rising edge after deassertion loads i_inst fetched at RESET_PC.
- Redirect latency: redirect sampled at edge n -> o_pc = target after edge n, IF/ID = NOP/invalid after edge n, and the target instruction is valid in IF/ID after edge n+1 (one bubble).
- Stall held k cycles: o_pc and IF/ID are constant for k cycles, then resume with PC+4.
- Flush and stall in the same cycle: flush applies to IF/ID and redirect applies to PC.
- Reset asserted mid-redirect: the redirect is lost, and the PC returns to RESET_PC.
- All outputs are registered; there is no combinational path from inputs to outputs.

## Structure
- Shared header pipeline_defs.vh holds NOP encoding (0), RESET_PC default, PC step (4), PC_WIDTH/INST_WIDTH defaults.
- Split into two always blocks: PC register and IF/ID register.
- One natural sub-module: sat_counter (parameterised width, async active-low reset, enable, saturate).

## Test plan
- Reset then free-run with i_inst = PC-derived pattern -> o_pc = 0x00400000, 0x00400004, 0x00400008; IF/ID valid from the second cycle with pc_plus4 = 0x00400004.
- Jump to 0x00400100 with flush at PC 0x00400008 -> next o_pc = 0x00400100, IF/ID NOP/valid 0 for one cycle, then inst@0x00400100 with pc_plus4 = 0x00400104; flush_count = 1.
- Branch_taken to 0x00400020 and jump to 0x00400100 in the same cycle, plus stall -> o_pc = 0x00400020, IF/ID flushed, no protocol error.
- Stall for 3 cycles, no flush -> o_pc and IF/ID constant for 3 cycles, then PC+4.
- Flush without jump/branch -> o_protocol_err = 1 and stays 1; misaligned target 0x00400103 -> o_pc = 0x00400100.
- PC = 0xFFFFFFFC sequential -> 0x00000000; 65536 flush cycles -> o_flush_count = 0xFFFF; async reset mid-stream -> all outputs return to reset values immediately.

Source files
------------

// File: rtl/if_id_redirect_pkg.sv
// Shared fetch-stage definitions: default widths, reset PC, PC step, NOP
// encoding and the next-PC source selector.
package if_id_redirect_pkg;
   localparam int          DEF_PC_WIDTH   = 32;
   localparam int          DEF_INST_WIDTH = 32;
   localparam int          DEF_CNT_WIDTH  = 16;
   localparam logic [31:0] DEF_RESET_PC   = 32'h0040_0000;
   localparam int          PC_STEP        = 4;
   localparam logic [31:0] NOP_INST       = 32'h0000_0000;

   typedef enum logic [1:0] {
      PC_SEQ,
      PC_HOLD,
      PC_JUMP,
      PC_BRANCH
   } pc_sel_e;
endpackage

// File: rtl/if_id_redirect_if.sv
// Hazard/redirect request and IF/ID result bundle between the fetch stage
// and its neighbours (hazard unit, ID, EX, instruction memory).
interface if_id_redirect_if
   import if_id_redirect_pkg::*;
#(
   parameter int PC_WIDTH   = DEF_PC_WIDTH,
   parameter int INST_WIDTH = DEF_INST_WIDTH,
   parameter int CNT_WIDTH  = DEF_CNT_WIDTH
);
   logic                  i_stall;
   logic                  i_IF_ID_Flush;
   logic                  i_jump;
   logic [PC_WIDTH-1:0]   i_jump_target;
   logic                  i_branch_taken;
   logic [PC_WIDTH-1:0]   i_branch_target;
   logic [INST_WIDTH-1:0] i_inst;
   logic [PC_WIDTH-1:0]   o_pc;
   logic [INST_WIDTH-1:0] o_IF_ID_inst;
   logic [PC_WIDTH-1:0]   o_IF_ID_pc_plus4;
   logic                  o_IF_ID_valid;
   logic [CNT_WIDTH-1:0]  o_flush_count;
   logic                  o_protocol_err;

   modport master (
      output i_stall, i_IF_ID_Flush, i_jump, i_jump_target,
             i_branch_taken, i_branch_target, i_inst,
      input  o_pc, o_IF_ID_inst, o_IF_ID_pc_plus4, o_IF_ID_valid,
             o_flush_count, o_protocol_err
   );

   modport slave (
      input  i_stall, i_IF_ID_Flush, i_jump, i_jump_target,
             i_branch_taken, i_branch_target, i_inst,
      output o_pc, o_IF_ID_inst, o_IF_ID_pc_plus4, o_IF_ID_valid,
             o_flush_count, o_protocol_err
   );
endinterface

// File: rtl/if_id_redirect_sat_counter.sv
// Saturating up-counter: increments on enable, sticks at all-ones.
module if_id_redirect_sat_counter
   import if_id_redirect_pkg::*;
#(
   parameter int WIDTH = DEF_CNT_WIDTH
) (
   input  logic             i_clk,
   input  logic             i_rst_n,
   input  logic             i_en,
   output logic [WIDTH-1:0] o_count
);
   logic [WIDTH-1:0] count_q;

   function automatic logic [WIDTH-1:0] sat_inc(input logic [WIDTH-1:0] v);
      return (&v) ? v : v + 1'b1;
   endfunction

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n)
         count_q <= '0;
      else if (i_en)
         count_q <= sat_inc(count_q);
   end

   assign o_count = count_q;
endmodule

// File: rtl/if_id_redirect.sv
// Fetch PC register and IF/ID pipeline register with branch/jump redirect,
// stall/flush handling, flush counting and a sticky flush/redirect mismatch flag.
module if_id_redirect
   import if_id_redirect_pkg::*;
#(
   parameter int                  PC_WIDTH   = DEF_PC_WIDTH,
   parameter int                  INST_WIDTH = DEF_INST_WIDTH,
   parameter int                  CNT_WIDTH  = DEF_CNT_WIDTH,
   parameter logic [PC_WIDTH-1:0] RESET_PC   = PC_WIDTH'(DEF_RESET_PC)
) (
   input  logic            i_clk,
   input  logic            i_rst_n,
   if_id_redirect_if.slave bus
);
   localparam logic [PC_WIDTH-1:0]   PC_INC     = PC_WIDTH'(PC_STEP);
   localparam logic [PC_WIDTH-1:0]   ALIGN_MASK = ~PC_WIDTH'(PC_STEP - 1);
   localparam logic [INST_WIDTH-1:0] NOP        = INST_WIDTH'(NOP_INST);

   // Targets are forced word-aligned so a corrupt low address never reaches memory.
   function automatic logic [PC_WIDTH-1:0] align_pc(input logic [PC_WIDTH-1:0] t);
      return t & ALIGN_MASK;
   endfunction

   pc_sel_e               pc_sel;
   logic [PC_WIDTH-1:0]   pc_p0;
   logic [PC_WIDTH-1:0]   pc_nxt;
   logic [PC_WIDTH-1:0]   pc_plus4;
   logic [INST_WIDTH-1:0] inst_p1;
   logic [PC_WIDTH-1:0]   pc_plus4_p1;
   logic                  vld_p1;
   logic                  err_q;
   logic [CNT_WIDTH-1:0]  flush_cnt;
   logic                  mismatch;

   assign pc_plus4 = pc_p0 + PC_INC;
   assign mismatch = bus.i_IF_ID_Flush != (bus.i_jump | bus.i_branch_taken);

   // Branch is older than the jump in ID, so it wins; any redirect overrides stall.
   always_comb begin
      pc_sel = PC_SEQ;
      if (bus.i_branch_taken)
         pc_sel = PC_BRANCH;
      else if (bus.i_jump)
         pc_sel = PC_JUMP;
      else if (bus.i_stall)
         pc_sel = PC_HOLD;
   end

   always_comb begin
      pc_nxt = pc_plus4;
      case (pc_sel)
         PC_BRANCH: pc_nxt = align_pc(bus.i_branch_target);
         PC_JUMP:   pc_nxt = align_pc(bus.i_jump_target);
         PC_HOLD:   pc_nxt = pc_p0;
         default:   pc_nxt = pc_plus4;
      endcase
   end

   // Stage p0: fetch PC
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n)
         pc_p0 <= RESET_PC;
      else
         pc_p0 <= pc_nxt;
   end

   // Stage p1: IF/ID register
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         inst_p1     <= '0;
         pc_plus4_p1 <= '0;
         vld_p1      <= 1'b0;
      end else if (bus.i_IF_ID_Flush) begin
         inst_p1     <= NOP;
         pc_plus4_p1 <= '0;
         vld_p1      <= 1'b0;
      end else if (!bus.i_stall) begin
         inst_p1     <= bus.i_inst;
         pc_plus4_p1 <= pc_plus4;
         vld_p1      <= 1'b1;
      end
   end

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n)
         err_q <= 1'b0;
      else if (mismatch)
         err_q <= 1'b1;
   end

   if_id_redirect_sat_counter #(
      .WIDTH (CNT_WIDTH)
   ) u_flush_cnt (
      .i_clk   (i_clk),
      .i_rst_n (i_rst_n),
      .i_en    (bus.i_IF_ID_Flush),
      .o_count (flush_cnt)
   );

   assign bus.o_pc             = pc_p0;
   assign bus.o_IF_ID_inst     = inst_p1;
   assign bus.o_IF_ID_pc_plus4 = pc_plus4_p1;
   assign bus.o_IF_ID_valid    = vld_p1;
   assign bus.o_flush_count    = flush_cnt;
   assign bus.o_protocol_err   = err_q;
endmodule
